commit_trace_buffer: RTL

//   On-chip capture of the CPU's architectural commit stream.

---
 rtl/commit_trace_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures WB register writes and EX overflows into a
// small FIFO that a debug host drains over a first-word-fall-through
// valid/ready port. Up to two entries are pushed per cycle: the WB entry goes
// first because it belongs to the older instruction.
module commit_trace_buffer #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int FREEZE_ON_EXC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          clear,
  input  logic          wb_valid,
  input  logic [3:0]    wb_reg,
  input  logic [15:0]   wb_data,
  input  logic          exc_valid,
  input  logic [15:0]   exc_pc,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [21:0]   rd_data,
  output logic [AW:0]   count,
  output logic [7:0]    dropped,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    FROZEN = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [21:0]   mem_q [DEPTH];
  logic [21:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dropped_q, dropped_d;

  logic          pop;
  logic          capture;
  logic          req_wb;
  logic          req_exc;
  logic          wr_wb;
  logic          wr_exc;
  logic [AW+1:0] free_slots;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [8:0]    drop_sum;
  logic [21:0]   wb_entry;
  logic [21:0]   exc_entry;

  assign wb_entry  = {2'b00, wb_reg, wb_data};
  assign exc_entry = {2'b01, 4'hF, exc_pc};

  // Decide how many of this cycle's requests fit, counting a same-cycle pop as free space
  always_comb begin
    pop        = (count_q != '0) && rd_ready;
    capture    = (state_q == ARMED) && !clear;
    req_wb     = capture && wb_valid;
    req_exc    = capture && exc_valid;
    free_slots = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(pop);
    wr_wb      = req_wb && (free_slots != '0);
    wr_exc     = req_exc && (free_slots > (AW+2)'(wr_wb));
    n_push     = {1'b0, wr_wb} + {1'b0, wr_exc};
    n_drop     = ({1'b0, req_wb} + {1'b0, req_exc}) - n_push;
  end

  // Capture state machine: clear wins over arm, and an overflow freezes capture when enabled
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (exc_valid && (FREEZE_ON_EXC != 0)) state_d = FROZEN;
        FROZEN:  if (arm) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next storage, pointers, occupancy and saturating drop counter
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    drop_sum  = {1'b0, dropped_q} + {7'd0, n_drop};
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = '0;
    end else begin
      if (wr_wb) begin
        mem_d[wr_ptr_q] = wb_entry;
      end
      if (wr_exc) begin
        mem_d[wr_ptr_q + AW'(wr_wb)] = exc_entry;
      end
      wr_ptr_d  = wr_ptr_q + AW'(n_push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
      dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Entry storage needs no reset: rd_data is masked to zero while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 22'd0;
  assign count    = count_q;
  assign dropped  = dropped_q;
  assign state    = state_q;

endmodule
